mod_74x165_frame_tx: RTL and testbench
======================================

Name: mod_74x165_frame_tx

Overview:
- Parallel-in, serial-out frame transmitter built around 74x165-style shift behaviour.
- Accepts a parallel word through a valid/ready handshake and shifts it out on a single line as a framed sequence: start bit, data MSB-first, odd parity, stop bit.
- Each bit is held for a programmable number of clocks.
- Serves as the sending end for serial links between 74xx-modelled boards, and as a sequential stimulus source for gate-level module benches.

Parameters:
- WIDTH, 8, data bits per frame (legal range 1..32).
- DIV, 4, clocks each serial bit is held on Q (legal range 1..65535).

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- CLR_n  input  1  asynchronous active-low reset.
- D  input  WIDTH  parallel data word, sampled on an accepted load.
- LOAD  input  1  load request (valid).
- READY  output  1  block can accept a word this cycle.
- Q  output  1  serial line; idle level 1.
- BUSY  output  1  frame in progress.
- DONE  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset:
  - CLR_n low forces, immediately and independent of CLK: state=IDLE, Q=1, READY=1, BUSY=0, DONE=0, bit-time counter=0, bit index=0, shift register=0.
  - Reset asserted mid-frame aborts the frame. The partial word is discarded and is not resent.
  - Release of CLR_n takes effect at the next rising edge.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Q=1, READY=1, BUSY=0.
  - Accept happens at a rising edge with LOAD=1 and READY=1.
  - On accept: D is captured into the shift register, the parity bit (XOR-reduce of D, inverted, i.e. odd parity) is captured, and the next state is START.
- START: Q=0 for exactly DIV cycles, then DATA.
- DATA:
  - Q = shift register MSB (D[WIDTH-1] first, D[0] last).
  - Each bit is held DIV cycles, and the register shifts left once per bit time.
  - After WIDTH bits, go to PARITY.
- PARITY: Q = captured parity bit for DIV cycles, then STOP.
- STOP: Q=1 for DIV cycles, then IDLE.
- Timing:
  - Q changes only on rising edges.
  - The first start-bit cycle is the cycle immediately after the accepting edge (latency 1 clock).
  - Total frame length = (WIDTH+3)*DIV cycles.
- Handshake and status outputs:
  - READY=0 and BUSY=1 in every non-IDLE state.
  - LOAD while busy is ignored; the word is not queued.
  - D is don't-care except at the accepting edge; changes to D during a frame do not affect Q.
- DONE:
  - High for exactly one cycle: the first IDLE cycle after STOP completes.
  - READY=1 in that same cycle.
  - If LOAD=1 in the DONE cycle, the next frame is accepted at that edge. This gives back-to-back frames with one idle-level cycle between stop and start.
- Counters:
  - The bit-time counter counts 0..DIV-1 and wraps to 0 at each bit boundary.
  - The bit index counts 0..WIDTH-1 in DATA.
  - Counter widths are sized by clog2 of the parameter (minimum 1 bit).
  - DIV=1 gives one clock per bit with no special casing.
- Simultaneous CLR_n low and LOAD high: reset wins, and nothing is accepted.

Test Plan:
- Reset values: CLR_n=0 for 3 cycles with LOAD=1 and D=8'hFF -> Q=1, READY=1, BUSY=0, DONE=0 throughout; no frame starts after release until a LOAD edge.
- Basic frame, WIDTH=8, DIV=4: D=8'hA5 with a one-cycle LOAD -> Q sequence by bit is 0 | 1,0,1,0,0,1,0,1 | 1 (parity) | 1 (stop), each bit held 4 cycles. BUSY is high for 44 cycles, then DONE pulses once with READY=1.
- Parity check: D=8'h01 -> parity bit 0; D=8'h00 -> parity bit 1; D=8'hFF -> parity bit 1.
- Busy rejection: assert LOAD with D=8'h3C at cycle 10 of an 8'hA5 frame -> the serial stream stays the 8'hA5 frame and no second frame follows.
- Back-to-back, DIV=1: hold LOAD=1 with D=8'h81, then D=8'h7E -> frame 1 takes 11 cycles, DONE cycle (Q=1), then frame 2 starts immediately. Total 23 cycles from the first accept to the second DONE.
- Abort: pull CLR_n low at cycle 17 of a frame -> Q=1 and READY=1 in the same timestep without a clock edge. After release, LOAD with D=8'h55 produces a clean full frame.

Source files
------------

// File: rtl/mod_74x165_frame_tx.sv
// Framed parallel-in/serial-out transmitter: start bit, WIDTH data bits MSB-first,
// odd parity, stop bit, each bit held DIV clocks on Q.
module mod_74x165_frame_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD,
  output logic             READY,
  output logic             Q,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             par_q, par_d;
  logic             done_q, done_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_W'(DIV - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    par_d   = par_q;
    done_d  = 1'b0;
    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (LOAD) begin
          sr_d    = D;
          par_d   = ~(^D);
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          sr_d = sr_q << 1;
          if (idx_q == IDX_W'(WIDTH - 1)) begin
            idx_d   = '0;
            state_d = S_PARITY;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sr_q    <= '0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      par_q   <= par_d;
      done_q  <= done_d;
    end
  end

  // Q is decoded from registered state only, so it moves solely on clock edges or reset.
  always_comb begin
    case (state_q)
      S_START:  Q = 1'b0;
      S_DATA:   Q = sr_q[WIDTH-1];
      S_PARITY: Q = par_q;
      default:  Q = 1'b1;
    endcase
  end

  assign READY = (state_q == S_IDLE);
  assign BUSY  = (state_q != S_IDLE);
  assign DONE  = done_q;

endmodule

// File: tb/tb_mod_74x165_frame_tx.sv
// Directed bench: DUT a runs WIDTH=8/DIV=4, DUT b runs WIDTH=8/DIV=1 for back-to-back frames.
module tb_mod_74x165_frame_tx;

  logic       clk = 1'b0;
  logic       clr_a, load_a, ready_a, q_a, busy_a, done_a;
  logic [7:0] d_a;
  logic       clr_b, load_b, ready_b, q_b, busy_b, done_b;
  logic [7:0] d_b;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  mod_74x165_frame_tx #(.WIDTH(8), .DIV(4)) dut_a (
    .CLK(clk), .CLR_n(clr_a), .D(d_a), .LOAD(load_a),
    .READY(ready_a), .Q(q_a), .BUSY(busy_a), .DONE(done_a)
  );

  mod_74x165_frame_tx #(.WIDTH(8), .DIV(1)) dut_b (
    .CLK(clk), .CLR_n(clr_b), .D(d_b), .LOAD(load_b),
    .READY(ready_b), .Q(q_b), .BUSY(busy_b), .DONE(done_b)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    clr_a = 1'b0; load_a = 1'b1; d_a = 8'hFF;
    clr_b = 1'b0; load_b = 1'b0; d_b = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({q_a, ready_a, busy_a, done_a} !== 4'b1100) begin
        errors++;
        $display("FAIL reset cycle %0d: q/ready/busy/done=%b want 1100", i, {q_a, ready_a, busy_a, done_a});
      end
    end
    clr_a = 1'b1; clr_b = 1'b1; load_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({q_a, ready_a, busy_a, done_a} !== 4'b1100) begin
        errors++;
        $display("FAIL post_reset_idle cycle %0d: q/ready/busy/done=%b want 1100", i, {q_a, ready_a, busy_a, done_a});
      end
    end
  endtask

  // Sends one frame on dut_a; par is the hand-computed parity bit.
  task automatic send_a(input logic [7:0] dv, input logic par, input bit inject, input string nm);
    logic [10:0] exp;
    exp = {1'b0, dv, par, 1'b1};
    @(negedge clk);
    d_a = dv; load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0; d_a = ~dv;
    for (int c = 0; c < 44; c++) begin
      checks++;
      if (q_a !== exp[10 - c/4]) begin
        errors++;
        $display("FAIL %s q cycle %0d: got %b want %b", nm, c + 1, q_a, exp[10 - c/4]);
      end
      checks++;
      if ({busy_a, ready_a, done_a} !== 3'b100) begin
        errors++;
        $display("FAIL %s status cycle %0d: busy/ready/done=%b want 100", nm, c + 1, {busy_a, ready_a, done_a});
      end
      if (inject && c == 9) begin load_a = 1'b1; d_a = 8'h3C; end
      if (inject && c == 10) load_a = 1'b0;
      @(negedge clk);
    end
    checks++;
    if ({done_a, ready_a, busy_a, q_a} !== 4'b1101) begin
      errors++;
      $display("FAIL %s done_cycle: done/ready/busy/q=%b want 1101", nm, {done_a, ready_a, busy_a, q_a});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({done_a, ready_a, busy_a, q_a} !== 4'b0101) begin
        errors++;
        $display("FAIL %s after_done %0d: done/ready/busy/q=%b want 0101", nm, i, {done_a, ready_a, busy_a, q_a});
      end
    end
  endtask

  task automatic test_basic_frame();
    send_a(8'hA5, 1'b1, 1'b0, "frame_a5");
  endtask

  task automatic test_parity();
    send_a(8'h01, 1'b0, 1'b0, "parity_01");
    send_a(8'h00, 1'b1, 1'b0, "parity_00");
    send_a(8'hFF, 1'b1, 1'b0, "parity_ff");
  endtask

  task automatic test_busy_reject();
    send_a(8'hA5, 1'b1, 1'b1, "busy_reject");
  endtask

  task automatic test_back_to_back();
    bit qexp [24] = '{0,1,0,0,0,0,0,0,1,1,1, 1, 0,0,1,1,1,1,1,1,0,1,1, 1};
    @(negedge clk);
    d_b = 8'h81; load_b = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c == 0) d_b = 8'h7E;
      checks++;
      if (q_b !== qexp[c]) begin
        errors++;
        $display("FAIL b2b q cycle %0d: got %b want %b", c + 1, q_b, qexp[c]);
      end
      checks++;
      if (done_b !== ((c == 11) || (c == 23)) || busy_b !== !((c == 11) || (c == 23))) begin
        errors++;
        $display("FAIL b2b status cycle %0d: done=%b busy=%b", c + 1, done_b, busy_b);
      end
    end
    load_b = 1'b0;
    @(negedge clk);
    checks++;
    if ({done_b, ready_b, busy_b, q_b} !== 4'b0101) begin
      errors++;
      $display("FAIL b2b idle_after: done/ready/busy/q=%b want 0101", {done_b, ready_b, busy_b, q_b});
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    d_a = 8'hA5; load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    repeat (16) @(negedge clk);
    checks++;
    if (q_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL abort pre: q=%b busy=%b want q=0 busy=1", q_a, busy_a);
    end
    clr_a = 1'b0;
    #1;
    checks++;
    if ({q_a, ready_a, busy_a, done_a} !== 4'b1100) begin
      errors++;
      $display("FAIL abort async: q/ready/busy/done=%b want 1100", {q_a, ready_a, busy_a, done_a});
    end
    @(negedge clk);
    clr_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({q_a, ready_a, busy_a, done_a} !== 4'b1100) begin
        errors++;
        $display("FAIL abort idle %0d: q/ready/busy/done=%b want 1100", i, {q_a, ready_a, busy_a, done_a});
      end
    end
    send_a(8'h55, 1'b1, 1'b0, "abort_55");
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_busy_reject();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
